// File: rtl/board_input_conditioner_pkg.sv
// Shared types and constants for the board input conditioning path.
// Holds the start-up FSM encoding and default debounce timing.
package board_io_pkg;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam int CLK_HZ                  = 50000000;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;  // 20 ms at CLK_HZ

endpackage

// File: rtl/board_input_conditioner_if.sv
// Bundle of raw board pins and their conditioned counterparts.
// The master side owns the pins; the slave side is the conditioner.
interface board_input_conditioner_if #(
  parameter int NUM_KEYS = 4,
  parameter int NUM_SW   = 10
);
  import board_io_pkg::*;

  logic [NUM_KEYS-1:0] KEY_raw;
  logic [NUM_SW-1:0]   SW_raw;
  // ready is a level qualifier, not a handshake: once high, every conditioned
  // output is valid each cycle and nothing is ever back-pressured.
  logic                ready;
  logic [NUM_KEYS-1:0] key_down;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_SW-1:0]   sw_level;
  logic [NUM_SW-1:0]   sw_change;
  state_t              fsm_state;

  modport master (
    output KEY_raw, SW_raw,
    input  ready, key_down, key_press, key_release, sw_level, sw_change, fsm_state
  );

  modport slave (
    input  KEY_raw, SW_raw,
    output ready, key_down, key_press, key_release, sw_level, sw_change, fsm_state
  );

endinterface

// File: rtl/board_input_conditioner_debounce_cell.sv
// One input: 2-flop synchroniser, debounce counter, stable level and
// registered one-cycle rise/fall pulses.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic load,
  input  logic run,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync0;
  logic             sync1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (load) begin
        // Initial capture adopts the synchronised value without a pulse.
        level <= sync1;
        cnt   <= '0;
      end else if (run) begin
        if (sync1 == level) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          level <= sync1;
          cnt   <= '0;
          rise  <= sync1;
          fall  <= ~sync1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/board_input_conditioner.sv
// Conditions DE-series KEY/SW pins into debounced levels and edge pulses,
// with a start-up FSM that captures initial positions silently.
module board_input_conditioner
  import board_io_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int NUM_SW          = 10,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20
) (
  input  logic                      CLOCK_50,
  input  logic                      Resetn,
  board_input_conditioner_if.slave  io
);

  state_t state;
  state_t state_nxt;
  logic   fill_cnt;
  logic   fill_nxt;
  logic   load;
  logic   run;

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state    <= S_FILL;
      fill_cnt <= 1'b0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_nxt;
    end
  end

  // S_FILL waits two edges so the synchronisers hold real samples before S_LOAD.
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_cnt;
    load      = 1'b0;
    run       = 1'b0;
    case (state)
      S_FILL: begin
        if (fill_cnt) state_nxt = S_LOAD;
        else          fill_nxt  = 1'b1;
      end
      S_LOAD: begin
        load      = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN:   run       = 1'b1;
      default: state_nxt = S_FILL;
    endcase
  end

  assign io.ready     = (state == S_RUN);
  assign io.fsm_state = state;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_cell (
      .clk   (CLOCK_50),
      .rst_n (Resetn),
      .raw   (~io.KEY_raw[i]),
      .load  (load),
      .run   (run),
      .level (io.key_down[i]),
      .rise  (io.key_press[i]),
      .fall  (io.key_release[i])
    );
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    logic sw_rise;
    logic sw_fall;

    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_cell (
      .clk   (CLOCK_50),
      .rst_n (Resetn),
      .raw   (io.SW_raw[i]),
      .load  (load),
      .run   (run),
      .level (io.sw_level[i]),
      .rise  (sw_rise),
      .fall  (sw_fall)
    );

    assign io.sw_change[i] = sw_rise | sw_fall;
  end

endmodule

// File: tb/tb_board_input_conditioner.sv
// Directed bench for board_input_conditioner with a short debounce window.
module tb_board_input_conditioner;
  import board_io_pkg::*;

  localparam int NK = 4;
  localparam int NS = 10;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  board_input_conditioner_if #(.NUM_KEYS(NK), .NUM_SW(NS)) bif ();

  board_input_conditioner #(
    .NUM_KEYS        (NK),
    .NUM_SW          (NS),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .CLOCK_50 (clk),
    .Resetn   (rst_n),
    .io       (bif)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    bif.KEY_raw = 4'hF;
    bif.SW_raw  = 10'h2A5;
    repeat (3) tick();

    // reset state
    check("rst_ready", 32'(bif.ready), 32'd0);
    check("rst_state", 32'(bif.fsm_state), 32'(S_FILL));
    check("rst_key_down", 32'(bif.key_down), 32'd0);
    check("rst_sw_level", 32'(bif.sw_level), 32'd0);

    // start-up capture: ready after the third edge
    rst_n = 1'b1;
    tick();
    check("su1_ready", 32'(bif.ready), 32'd0);
    check("su1_state", 32'(bif.fsm_state), 32'(S_FILL));
    check("su1_change", 32'(bif.sw_change), 32'd0);
    tick();
    check("su2_ready", 32'(bif.ready), 32'd0);
    check("su2_state", 32'(bif.fsm_state), 32'(S_LOAD));
    check("su2_change", 32'(bif.sw_change), 32'd0);
    tick();
    check("su3_ready", 32'(bif.ready), 32'd1);
    check("su3_state", 32'(bif.fsm_state), 32'(S_RUN));
    check("su3_sw_level", 32'(bif.sw_level), 32'h2A5);
    check("su3_change", 32'(bif.sw_change), 32'd0);
    check("su3_key_down", 32'(bif.key_down), 32'd0);
    check("su3_press", 32'(bif.key_press), 32'd0);

    // clean press on KEY[1]: level and pulse at edge 6
    bif.KEY_raw[1] = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("press_lvl", 32'(bif.key_down[1]), 32'(e >= 6));
      check("press_pls", 32'(bif.key_press[1]), 32'(e == 6));
      check("press_rel", 32'(bif.key_release), 32'd0);
      check("press_sw", 32'(bif.sw_change), 32'd0);
    end

    // bounce on KEY[2]: pressed 2, released 2, then held -> pulse at edge 10
    for (int e = 1; e <= 12; e++) begin
      if (e == 1 || e == 5) bif.KEY_raw[2] = 1'b0;
      if (e == 3)           bif.KEY_raw[2] = 1'b1;
      tick();
      check("bnc_lvl", 32'(bif.key_down[2]), 32'(e >= 10));
      check("bnc_pls", 32'(bif.key_press[2]), 32'(e == 10));
      check("bnc_rel", 32'(bif.key_release), 32'd0);
    end

    // SW[9] held low: one change pulse at edge 6
    bif.SW_raw[9] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check("sw9_dn_chg", 32'(bif.sw_change), (e == 6) ? 32'h200 : 32'd0);
      check("sw9_dn_lvl", 32'(bif.sw_level[9]), 32'(e < 6));
    end

    // SW[9] high for three cycles only: no change
    for (int e = 1; e <= 10; e++) begin
      bif.SW_raw[9] = (e <= 3);
      tick();
      check("sw9_gl_chg", 32'(bif.sw_change), 32'd0);
      check("sw9_gl_lvl", 32'(bif.sw_level[9]), 32'd0);
    end

    // SW[9] held high: one change pulse, level 1
    bif.SW_raw[9] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check("sw9_up_chg", 32'(bif.sw_change), (e == 6) ? 32'h200 : 32'd0);
      check("sw9_up_lvl", 32'(bif.sw_level[9]), 32'(e >= 6));
    end
    check("sw_all_lvl", 32'(bif.sw_level), 32'h2A5);

    // press KEY[0] so it can be released later
    bif.KEY_raw[0] = 1'b0;
    repeat (8) tick();
    check("k0_down", 32'(bif.key_down), 32'h7);

    // simultaneous KEY[0] release and SW[0] flip
    bif.KEY_raw[0] = 1'b1;
    bif.SW_raw[0]  = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("sim_rel", 32'(bif.key_release), (e == 6) ? 32'h1 : 32'd0);
      check("sim_chg", 32'(bif.sw_change), (e == 6) ? 32'h1 : 32'd0);
      check("sim_press", 32'(bif.key_press), 32'd0);
    end
    check("sim_key_down", 32'(bif.key_down), 32'h6);
    check("sim_sw_level", 32'(bif.sw_level), 32'h2A4);

    // KEY[3] count reaches 2, then asynchronous reset
    bif.KEY_raw[3] = 1'b0;
    repeat (4) tick();
    check("mid_key_down", 32'(bif.key_down), 32'h6);
    rst_n = 1'b0;
    #2;
    check("mid_rst_ready", 32'(bif.ready), 32'd0);
    check("mid_rst_keys", 32'(bif.key_down), 32'd0);
    check("mid_rst_sw", 32'(bif.sw_level), 32'd0);
    check("mid_rst_state", 32'(bif.fsm_state), 32'(S_FILL));
    repeat (2) tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check("re_ready", 32'(bif.ready), 32'(e >= 3));
      check("re_press", 32'(bif.key_press), 32'd0);
      check("re_rel", 32'(bif.key_release), 32'd0);
      check("re_chg", 32'(bif.sw_change), 32'd0);
      check("re_keys", 32'(bif.key_down), (e >= 3) ? 32'hE : 32'd0);
      check("re_sw", 32'(bif.sw_level), (e >= 3) ? 32'h2A4 : 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
